// File: rtl/secded_encoder.sv
// -----------------------------------------------------------------------------
// secded_encoder
//
// Encode side of the 32-bit SECDED path. Each 32-bit data word gets six
// Hamming check bits plus one overall even-parity bit (parity_DED). The
// block is a two-stage valid/ready pipeline:
//   stage 1 : registers the accepted data word and its Hamming check bits
//   stage 2 : registers data, check bits and the overall parity bit computed
//             from the stage-1 registers; this stage drives the outputs
//
// Codeword layout (positions 1..38, check bit i at position 2^i):
//   data[0]      -> 3
//   data[3:1]    -> 7..5
//   data[10:4]   -> 15..9
//   data[25:11]  -> 31..17
//   data[31:26]  -> 38..33
// parity[i] is the XOR of every data bit whose position has bit i set.
// parity_DED is the XOR of all 32 data bits and the 6 check bits, so the
// 39-bit codeword has even parity.
//
// Optional feature (macro SECDED_ERR_INJECT_EN):
//   adds input inj_mask[38:0]. The mask is captured with the data word on
//   input accept, travels through stage 1, and is XORed into the finished
//   codeword {parity_DED, parity[5:0], data[31:0]} in stage 2. With the
//   macro undefined the port does not exist and the codeword is always clean.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   in_valid       in   input word valid
//   in_ready       out  encoder can accept a word this cycle
//   in_data        in   data word to encode
//   inj_mask       in   error-injection mask (SECDED_ERR_INJECT_EN only)
//   out_valid      out  codeword valid
//   out_ready      in   downstream accepts codeword
//   out_data       out  data word (pass-through)
//   out_parity     out  Hamming check bits [5:0]
//   out_parity_DED out  overall even-parity bit
//   word_count     out  count of completed output handshakes (wraps)
// -----------------------------------------------------------------------------
module secded_encoder #(
  // Fixed at 32: the position map above is defined for 32 data bits only.
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
`ifdef SECDED_ERR_INJECT_EN
  input  logic [38:0]       inj_mask,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_parity,
  output logic              out_parity_DED,
  output logic [CNT_W-1:0]  word_count
);

  // ---------------------------------------------------------------------------
  // Check-bit coverage masks
  // ---------------------------------------------------------------------------
  // Bit k of the mask for check bit chk is set when data[k] lands on a
  // codeword position whose binary index has bit chk set. Data positions are
  // the non-power-of-two numbers in 1..38, taken in ascending order.
  function automatic logic [DATA_W-1:0] cover_mask(input int unsigned chk);
    logic [DATA_W-1:0] m;
    logic [5:0]        pos;
    int unsigned       idx;
    m   = '0;
    idx = 0;
    for (int unsigned p = 1; p <= 38; p++) begin
      pos = p[5:0];
      if ((pos & (pos - 6'd1)) != 6'd0) begin
        m[idx[4:0]] = pos[chk[2:0]];
        idx++;
      end
    end
    return m;
  endfunction

  localparam logic [DATA_W-1:0] COVER_0 = cover_mask(0);
  localparam logic [DATA_W-1:0] COVER_1 = cover_mask(1);
  localparam logic [DATA_W-1:0] COVER_2 = cover_mask(2);
  localparam logic [DATA_W-1:0] COVER_3 = cover_mask(3);
  localparam logic [DATA_W-1:0] COVER_4 = cover_mask(4);
  localparam logic [DATA_W-1:0] COVER_5 = cover_mask(5);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Each check bit is a reduction XOR over its covered data bits.
  function automatic logic [5:0] hamming_check(input logic [DATA_W-1:0] d);
    return {^(d & COVER_5), ^(d & COVER_4), ^(d & COVER_3),
            ^(d & COVER_2), ^(d & COVER_1), ^(d & COVER_0)};
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic              s1_valid_q,  s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,   s1_data_d;
  logic [5:0]        s1_parity_q, s1_parity_d;

  logic              s2_valid_q,  s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,   s2_data_d;
  logic [5:0]        s2_parity_q, s2_parity_d;
  logic              s2_ded_q,    s2_ded_d;

  logic [CNT_W-1:0]  cnt_q,       cnt_d;

  logic [38:0]       s1_mask;
`ifdef SECDED_ERR_INJECT_EN
  logic [38:0]       s1_mask_q,   s1_mask_d;
  assign s1_mask = s1_mask_q;
`else
  assign s1_mask = '0;
`endif

  // The whole pipe moves when stage 2 is empty or its word is being taken.
  // A stall freezes both stages, which also back-pressures the input.
  logic adv;
  assign adv      = !s2_valid_q || out_ready;
  assign in_ready = adv;

  // Stage-2 codeword: overall parity is taken over the stage-1 registers,
  // then the injection mask (all-zero in the default build) is applied to
  // the finished codeword so injected errors never influence parity.
  logic        s1_ded;
  logic [38:0] s1_codeword;
  assign s1_ded      = ^s1_data_q ^ ^s1_parity_q;
  assign s1_codeword = {s1_ded, s1_parity_q, s1_data_q} ^ s1_mask;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a hold value first; a path that
    // leaves one unassigned would infer a latch instead of plain logic.
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_parity_d = s1_parity_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_parity_d = s2_parity_q;
    s2_ded_d    = s2_ded_q;
    cnt_d       = cnt_q;
`ifdef SECDED_ERR_INJECT_EN
    s1_mask_d   = s1_mask_q;
`endif

    if (adv) begin
      // in_ready equals adv, so an accept here is simply in_valid.
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d   = in_data;
        s1_parity_d = hamming_check(in_data);
`ifdef SECDED_ERR_INJECT_EN
        s1_mask_d   = inj_mask;
`endif
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d   = s1_codeword[31:0];
        s2_parity_d = s1_codeword[37:32];
        s2_ded_d    = s1_codeword[38];
      end
      // When stage 1 is empty the stage-2 data fields simply hold; only
      // s2_valid marks them as meaningful.
    end

    // Counts completed output handshakes; wraps naturally at 2^CNT_W.
    if (s2_valid_q && out_ready) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_parity_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_parity_q <= '0;
      s2_ded_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_parity_q <= s1_parity_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_parity_q <= s2_parity_d;
      s2_ded_q    <= s2_ded_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SECDED_ERR_INJECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mask_q <= '0;
    end else begin
      s1_mask_q <= s1_mask_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: driven straight from stage-2 registers
  // ---------------------------------------------------------------------------
  assign out_valid      = s2_valid_q;
  assign out_data       = s2_data_q;
  assign out_parity     = s2_parity_q;
  assign out_parity_DED = s2_ded_q;
  assign word_count     = cnt_q;

endmodule

// File: tb/tb_secded_encoder.sv
// -----------------------------------------------------------------------------
// tb_secded_encoder
//
// Self-checking bench for secded_encoder. The reference model places data
// bits on codeword positions and derives the check bits as the XOR of the
// positions of all set data bits; a matching checker recomputes the syndrome
// and overall parity of each emitted codeword. A second instance with
// CNT_W=4 exercises counter wrap. The error-injection scenario is built only
// when SECDED_ERR_INJECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_secded_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_parity;
  logic        out_parity_DED;
  logic [15:0] word_count;

  logic        w_in_valid;
  logic        w_in_ready;
  logic [31:0] w_in_data;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_data;
  logic [5:0]  w_out_parity;
  logic        w_out_parity_DED;
  logic [3:0]  w_word_count;

`ifdef SECDED_ERR_INJECT_EN
  logic [38:0] inj_mask;
`endif

  int total;
  int bad;

  logic [5:0] pos_of_data [32];

  secded_encoder #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
`ifdef SECDED_ERR_INJECT_EN
    .inj_mask       (inj_mask),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_parity     (out_parity),
    .out_parity_DED (out_parity_DED),
    .word_count     (word_count)
  );

  secded_encoder #(.DATA_W(32), .CNT_W(4)) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (w_in_valid),
    .in_ready       (w_in_ready),
    .in_data        (w_in_data),
`ifdef SECDED_ERR_INJECT_EN
    .inj_mask       (39'h0),
`endif
    .out_valid      (w_out_valid),
    .out_ready      (w_out_ready),
    .out_data       (w_out_data),
    .out_parity     (w_out_parity),
    .out_parity_DED (w_out_parity_DED),
    .word_count     (w_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // Data bits occupy the non-power-of-two positions 1..38 in ascending order.
  task automatic build_position_map();
    int p;
    p = 1;
    for (int k = 0; k < 32; k++) begin
      while ((p & (p - 1)) == 0) p++;
      pos_of_data[k[4:0]] = p[5:0];
      p++;
    end
  endtask

  // The Hamming check vector equals the XOR of the positions of the set data
  // bits; the same XOR over a received codeword yields its syndrome.
  function automatic logic [5:0] pos_xor(input logic [31:0] d);
    logic [5:0] acc;
    acc = '0;
    for (int k = 0; k < 32; k++)
      if (d[k[4:0]]) acc = acc ^ pos_of_data[k[4:0]];
    return acc;
  endfunction

  function automatic logic [38:0] ref_codeword(input logic [31:0] d);
    logic [5:0] par;
    par = pos_xor(d);
    return {(^d) ^ (^par), par, d};
  endfunction

  // Downstream SECDED checker: syndrome, double-error flag, corrected data.
  task automatic ded_check(input logic [38:0] cw, output logic [5:0] syn,
                           output logic dbl, output logic [31:0] fixed);
    logic overall;
    syn     = pos_xor(cw[31:0]) ^ cw[37:32];
    overall = ^cw;
    dbl     = !overall && (syn != 6'd0);
    fixed   = cw[31:0];
    if (overall) begin
      for (int k = 0; k < 32; k++)
        if (pos_of_data[k[4:0]] == syn) fixed[k[4:0]] = ~fixed[k[4:0]];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Entered just after a falling edge: drive inputs, let logic settle, report
  // what the coming rising edge will do, then move to the next falling edge.
  task automatic step(input logic v, input logic [31:0] d, input logic rdy,
                      output logic in_hs, output logic out_hs,
                      output logic ov, output logic ir, output logic [38:0] got);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    #1;
    in_hs  = in_valid && in_ready;
    out_hs = out_valid && out_ready;
    ov     = out_valid;
    ir     = in_ready;
    got    = {out_parity_DED, out_parity, out_data};
    @(negedge clk);
  endtask

  task automatic apply_reset();
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    w_in_valid  = 1'b0;
    w_in_data   = '0;
    w_out_ready = 1'b0;
`ifdef SECDED_ERR_INJECT_EN
    inj_mask    = '0;
`endif
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    apply_reset();
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    total++;
    if (word_count !== 16'd0) begin
      bad++; $display("FAIL reset_word_count got=%0d want=0", word_count);
    end
    @(negedge clk);
  endtask

  task automatic test_known_vectors();
    logic [31:0] words [4];
    logic [5:0]  want_par [4];
    logic        want_ded [4];
    logic        ih, oh, ov, ir;
    logic [38:0] got;
    int          n_out, first_ov;
    words = '{32'h0000_0000, 32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
    want_par = '{6'h00, 6'h03, 6'h26, 6'h18};
    want_ded = '{1'b0, 1'b1, 1'b0, 1'b0};
    apply_reset();
    n_out    = 0;
    first_ov = -1;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (word_count !== n_out[15:0]) begin
        bad++; $display("FAIL known_word_count step=%0d got=%0d want=%0d", i, word_count, n_out);
      end
      step(i < 4, (i < 4) ? words[i[1:0]] : 32'h0, 1'b1, ih, oh, ov, ir, got);
      if (ov && first_ov < 0) first_ov = i;
      if (oh && n_out < 4) begin
        total++;
        if (got !== {want_ded[n_out[1:0]], want_par[n_out[1:0]], words[n_out[1:0]]}) begin
          bad++; $display("FAIL known_codeword idx=%0d got=%h want=%h", n_out, got,
                          {want_ded[n_out[1:0]], want_par[n_out[1:0]], words[n_out[1:0]]});
        end
        n_out++;
      end
    end
    total++;
    if (first_ov != 2) begin
      bad++; $display("FAIL known_latency got=%0d want=2", first_ov);
    end
    total++;
    if (n_out != 4 || word_count !== 16'd4) begin
      bad++; $display("FAIL known_count outs=%0d word_count=%0d want=4", n_out, word_count);
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] exp_q [$];
    logic [31:0] cur, e, fixed;
    logic [38:0] got;
    logic [5:0]  syn;
    logic        ih, oh, ov, ir, dbl, v, rdy;
    int          sent, rcvd, cyc;
    apply_reset();
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    cur  = $urandom;
    while ((sent < 1000 || rcvd < sent) && cyc < 6000) begin
      v   = (sent < 1000) && ($urandom_range(3) != 0);
      rdy = ($urandom_range(3) != 0);
      step(v, cur, rdy, ih, oh, ov, ir, got);
      if (ih) begin
        exp_q.push_back(cur);
        sent++;
        cur = $urandom;
      end
      if (oh) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL random_spurious_output got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== ref_codeword(e)) begin
            bad++; $display("FAIL random_codeword idx=%0d got=%h want=%h", rcvd, got, ref_codeword(e));
          end
        end
        ded_check(got, syn, dbl, fixed);
        total++;
        if (syn !== 6'd0 || dbl !== 1'b0) begin
          bad++; $display("FAIL random_ded idx=%0d syndrome=%h double_error=%b want 0/0", rcvd, syn, dbl);
        end
        rcvd++;
      end
      cyc++;
    end
    total++;
    if (sent != 1000 || rcvd != 1000) begin
      bad++; $display("FAIL random_timeout sent=%0d received=%0d want=1000", sent, rcvd);
    end
    total++;
    if (word_count !== 16'(rcvd)) begin
      bad++; $display("FAIL random_word_count got=%0d want=%0d", word_count, rcvd);
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [31:0] pend [$];
    logic [31:0] exp_q [$];
    logic [31:0] w, e;
    logic [38:0] got, held;
    logic        ih, oh, ov, ir, rdy, stalled_prev;
    int          stall_left, n_out, cyc;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      pend.push_back(w);
      exp_q.push_back(w);
    end
    stall_left   = 5;
    n_out        = 0;
    cyc          = 0;
    stalled_prev = 1'b0;
    held         = '0;
    while (n_out < 3 && cyc < 40) begin
      // out_valid is registered, so it is stable when out_ready is chosen.
      rdy = !(out_valid && stall_left > 0);
      step(pend.size() > 0, (pend.size() > 0) ? pend[0] : 32'h0, rdy, ih, oh, ov, ir, got);
      if (ih) void'(pend.pop_front());
      if (ov && !rdy) begin
        stall_left--;
        total++;
        if (ir !== 1'b0) begin
          bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, ir);
        end
        if (stalled_prev) begin
          total++;
          if (got !== held) begin
            bad++; $display("FAIL stall_hold cyc=%0d got=%h want=%h", cyc, got, held);
          end
        end
        held         = got;
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (oh) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
        total++;
        if (got !== ref_codeword(e)) begin
          bad++; $display("FAIL stall_order idx=%0d got=%h want=%h", n_out, got, ref_codeword(e));
        end
        n_out++;
      end
      cyc++;
    end
    total++;
    if (n_out != 3 || stall_left != 0) begin
      bad++; $display("FAIL stall_outputs got=%0d stall_cycles_left=%0d want=3/0", n_out, stall_left);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b1, ih, oh, ov, ir, got);
      total++;
      if (ov !== 1'b0) begin
        bad++; $display("FAIL stall_duplicate cyc=%0d out_valid=%b want=0", i, ov);
      end
    end
    total++;
    if (word_count !== 16'd3) begin
      bad++; $display("FAIL stall_word_count got=%0d want=3", word_count);
    end
  endtask

  task automatic test_reset_midflight();
    logic [38:0] got;
    logic        ih, oh, ov, ir;
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b1, ih, oh, ov, ir, got);
    // Two words have completed; two more sit in stage 1 and stage 2.
    total++;
    if (word_count !== 16'd2 || out_valid !== 1'b1) begin
      bad++; $display("FAIL midflight_pre word_count=%0d out_valid=%b want=2/1", word_count, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL midflight_out_valid got=%b want=0", out_valid);
    end
    total++;
    if (word_count !== 16'd0) begin
      bad++; $display("FAIL midflight_word_count got=%0d want=0", word_count);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 32'h0, 1'b1, ih, oh, ov, ir, got);
      total++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        bad++; $display("FAIL midflight_stale cyc=%0d out_valid=%b in_ready=%b want=0/1", i, ov, ir);
      end
    end
  endtask

`ifdef SECDED_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [38:0] got, clean;
    logic [38:0] outs [$];
    logic [31:0] fixed;
    logic [5:0]  syn;
    logic        ih, oh, ov, ir, dbl;
    int          cyc;
    apply_reset();
    clean    = ref_codeword(32'h1234_5678);
    inj_mask = 39'h1;
    step(1'b1, 32'h1234_5678, 1'b1, ih, oh, ov, ir, got);
    inj_mask = 39'h3;
    step(1'b1, 32'h1234_5678, 1'b1, ih, oh, ov, ir, got);
    inj_mask = 39'h0;
    cyc = 0;
    while (outs.size() < 2 && cyc < 10) begin
      step(1'b0, 32'h0, 1'b1, ih, oh, ov, ir, got);
      if (oh) outs.push_back(got);
      cyc++;
    end
    total++;
    if (outs.size() != 2) begin
      bad++; $display("FAIL inject_timeout outputs=%0d want=2", outs.size());
    end else begin
      total++;
      if (outs[0] !== {clean[38:32], 32'h1234_5679}) begin
        bad++; $display("FAIL inject_single_word got=%h want=%h", outs[0], {clean[38:32], 32'h1234_5679});
      end
      ded_check(outs[0], syn, dbl, fixed);
      total++;
      if (dbl !== 1'b0 || fixed !== 32'h1234_5678) begin
        bad++; $display("FAIL inject_single_correct double_error=%b data=%h want=0/12345678", dbl, fixed);
      end
      ded_check(outs[1], syn, dbl, fixed);
      total++;
      if (dbl !== 1'b1) begin
        bad++; $display("FAIL inject_double double_error=%b want=1", dbl);
      end
    end
  endtask
`endif

  task automatic test_count_wrap();
    int accepted, hs, cyc;
    apply_reset();
    accepted = 0;
    hs       = 0;
    cyc      = 0;
    while (hs < 17 && cyc < 60) begin
      total++;
      if (w_word_count !== hs[3:0]) begin
        bad++; $display("FAIL wrap_progress hs=%0d got=%0d want=%0d", hs, w_word_count, hs[3:0]);
      end
      w_in_valid  = (accepted < 17);
      w_in_data   = $urandom;
      w_out_ready = 1'b1;
      #1;
      if (w_in_valid && w_in_ready) accepted++;
      if (w_out_valid && w_out_ready) hs++;
      @(negedge clk);
      cyc++;
    end
    w_in_valid = 1'b0;
    total++;
    if (hs != 17 || w_word_count !== 4'd1) begin
      bad++; $display("FAIL wrap_final handshakes=%0d word_count=%0d want=17/1", hs, w_word_count);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    build_position_map();
    @(negedge clk);
    test_reset();
    test_known_vectors();
    test_random_stream();
    test_back_to_back_stall();
    test_reset_midflight();
`ifdef SECDED_ERR_INJECT_EN
    test_err_inject();
`endif
    test_count_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
